// File: rtl/controlador_acceso_parqueo.sv
// Parking-gate access controller: registered Moore FSM with a wrong-PIN
// attempt counter and a gate-open timeout counter.
//
// Ports:
//   clock                   : system clock, rising edge
//   reset                   : synchronous, active-high
//   sensor_llegada_vehiculo : vehicle present at the gate (level)
//   sensor_ingreso_vehiculo : vehicle crossing the gate (level)
//   clave_ingresada [15:0]  : entered PIN, valid when clave_lista=1
//   clave_lista             : one-cycle PIN strobe
//   senal_compuerta         : 1 = gate open
//   senal_alarma_pin        : sticky wrong-PIN alarm
//   senal_alarma_bloqueo    : tailgating / lock alarm
module controlador_acceso_parqueo #(
    parameter logic [15:0] CLAVE_CORRECTA = 16'h1234,
    parameter int          MAX_INTENTOS   = 3,
    parameter int          TIMEOUT_CICLOS = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sensor_llegada_vehiculo,
    input  logic        sensor_ingreso_vehiculo,
    input  logic [15:0] clave_ingresada,
    input  logic        clave_lista,
    output logic        senal_compuerta,
    output logic        senal_alarma_pin,
    output logic        senal_alarma_bloqueo
);

    localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [1:0] ESPERA_VEHICULO   = 2'd0;
    localparam logic [1:0] ESPERA_CLAVE      = 2'd1;
    localparam logic [1:0] COMPUERTA_ABIERTA = 2'd2;
    localparam logic [1:0] BLOQUEO           = 2'd3;

    localparam logic [3:0]    INTENTOS_MAX = 4'(MAX_INTENTOS);
    localparam logic [CW-1:0] CNT_ULTIMO   = CW'(TIMEOUT_CICLOS - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    intentos_q, intentos_d;
    logic [CW-1:0] cnt_timeout_q, cnt_timeout_d;
    logic          compuerta_q, compuerta_d;
    logic          alarma_pin_q, alarma_pin_d;
    logic          alarma_bloqueo_q, alarma_bloqueo_d;

    logic clave_ok;
    assign clave_ok = clave_lista && (clave_ingresada == CLAVE_CORRECTA);

    always_comb begin
        state_d       = state_q;
        intentos_d    = intentos_q;
        cnt_timeout_d = cnt_timeout_q;
        alarma_pin_d  = alarma_pin_q;

        case (state_q)
            ESPERA_VEHICULO: begin
                if (sensor_llegada_vehiculo) begin
                    state_d = ESPERA_CLAVE;
                end
            end
            ESPERA_CLAVE: begin
                // A PIN strobe takes precedence over the vehicle leaving.
                if (clave_ok) begin
                    state_d       = COMPUERTA_ABIERTA;
                    intentos_d    = 4'd0;
                    alarma_pin_d  = 1'b0;
                    cnt_timeout_d = '0;
                end else if (clave_lista) begin
                    if (intentos_q < INTENTOS_MAX) begin
                        intentos_d = intentos_q + 4'd1;
                    end
                    if (intentos_d == INTENTOS_MAX) begin
                        alarma_pin_d = 1'b1;
                    end
                end else if (!sensor_llegada_vehiculo && !alarma_pin_q) begin
                    // An active PIN alarm pins the FSM here until a good PIN.
                    state_d = ESPERA_VEHICULO;
                end
            end
            COMPUERTA_ABIERTA: begin
                cnt_timeout_d = cnt_timeout_q + CW'(1);
                if (sensor_ingreso_vehiculo && sensor_llegada_vehiculo) begin
                    state_d = BLOQUEO;
                end else if (sensor_ingreso_vehiculo) begin
                    state_d = ESPERA_VEHICULO;
                end else if (cnt_timeout_q == CNT_ULTIMO) begin
                    state_d = ESPERA_VEHICULO;
                end
            end
            BLOQUEO: begin
                if (clave_ok) begin
                    state_d    = ESPERA_VEHICULO;
                    intentos_d = 4'd0;
                end
            end
            default: begin
                state_d = ESPERA_VEHICULO;
            end
        endcase

        // Outputs are registered from the next state so they change on
        // the same edge as the state itself.
        compuerta_d      = (state_d == COMPUERTA_ABIERTA);
        alarma_bloqueo_d = (state_d == BLOQUEO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ESPERA_VEHICULO;
            intentos_q       <= 4'd0;
            cnt_timeout_q    <= '0;
            compuerta_q      <= 1'b0;
            alarma_pin_q     <= 1'b0;
            alarma_bloqueo_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            intentos_q       <= intentos_d;
            cnt_timeout_q    <= cnt_timeout_d;
            compuerta_q      <= compuerta_d;
            alarma_pin_q     <= alarma_pin_d;
            alarma_bloqueo_q <= alarma_bloqueo_d;
        end
    end

    assign senal_compuerta      = compuerta_q;
    assign senal_alarma_pin     = alarma_pin_q;
    assign senal_alarma_bloqueo = alarma_bloqueo_q;

endmodule

// File: doc/controlador_acceso_parqueo.md
Name: controlador_acceso_parqueo

Overview:
Parking-gate access controller. It is the device-under-test driven by the parking tester: it consumes the vehicle sensors and the entered 16-bit PIN, and it drives the gate and the two alarm outputs. It is a single registered Moore FSM with an attempt counter and a gate-open timeout counter, and it sits between the sensor/keypad front-end and the gate actuator.

Parameters:
CLAVE_CORRECTA, 16'h1234, PIN that opens the gate and releases a lock.
MAX_INTENTOS, 3, number of consecutive wrong PINs that raises senal_alarma_pin; legal range 1..15.
TIMEOUT_CICLOS, 1000, number of cycles the gate stays open without an ingress before it auto-closes; minimum 2.

Ports:
clock  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-high.
sensor_llegada_vehiculo  input  1  level; a vehicle is present at the gate.
sensor_ingreso_vehiculo  input  1  level; a vehicle is crossing the gate.
clave_ingresada  input  16  PIN value; sampled only when clave_lista=1.
clave_lista  input  1  one-cycle strobe: clave_ingresada is valid this cycle.
senal_compuerta  output  1  1 = gate open.
senal_alarma_pin  output  1  wrong-PIN alarm.
senal_alarma_bloqueo  output  1  tailgating/lock alarm.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the clock edge, and overrides all other inputs.
- Reset values: state=ESPERA_VEHICULO, intentos=0, cnt_timeout=0, all three outputs = 0.
- Output timing: all outputs are registers computed from next-state and next-counter values. The rising edge that samples a triggering input updates state and outputs together, so the response is visible right after that edge (1-cycle latency from input change).
- States and outputs:
  - ESPERA_VEHICULO: compuerta=0.
  - ESPERA_CLAVE: compuerta=0.
  - COMPUERTA_ABIERTA: compuerta=1.
  - BLOQUEO: compuerta=0, alarma_bloqueo=1.
  - alarma_pin is a separate sticky flag, described under ESPERA_CLAVE.
- ESPERA_VEHICULO:
  - sensor_llegada_vehiculo=1 -> ESPERA_CLAVE; intentos unchanged.
  - clave_lista ignored.
- ESPERA_CLAVE:
  - clave_lista=1 and clave_ingresada==CLAVE_CORRECTA -> COMPUERTA_ABIERTA; intentos=0; alarma_pin=0; cnt_timeout=0.
  - clave_lista=1 and wrong PIN -> intentos = intentos+1, saturating at MAX_INTENTOS. When the new value reaches MAX_INTENTOS, alarma_pin=1. State stays ESPERA_CLAVE.
  - clave_lista=0 and sensor_llegada_vehiculo=0 -> ESPERA_VEHICULO, only if alarma_pin=0. While alarma_pin=1 the FSM stays in ESPERA_CLAVE until a correct PIN arrives.
  - Simultaneous clave_lista and llegada dropping: the PIN is processed and the departure is ignored that cycle.
- COMPUERTA_ABIERTA:
  - cnt_timeout increments every cycle.
  - sensor_ingreso_vehiculo=1 and sensor_llegada_vehiculo=1 (second vehicle behind the first) -> BLOQUEO; compuerta=0; alarma_bloqueo=1.
  - sensor_ingreso_vehiculo=1 and sensor_llegada_vehiculo=0 -> ESPERA_VEHICULO; compuerta=0.
  - Otherwise, cnt_timeout==TIMEOUT_CICLOS-1 -> ESPERA_VEHICULO; compuerta=0. The gate is therefore high for exactly TIMEOUT_CICLOS cycles.
  - Priority: bloqueo > normal ingress > timeout. clave_lista is ignored.
- BLOQUEO:
  - clave_lista=1 with the correct PIN -> ESPERA_VEHICULO; alarma_bloqueo=0; intentos=0.
  - Wrong PIN is ignored and not counted. Sensors are ignored.
- Widths:
  - intentos is 4 bits and never wraps.
  - cnt_timeout is $clog2(TIMEOUT_CICLOS) bits and is cleared on every entry to COMPUERTA_ABIERTA.
  - PIN compare is an exact 16-bit equality.
- Reset mid-operation (any state, including gate open or alarm active): the next edge returns to the reset values. The gate closes and the alarms clear immediately.
- Undefined or unused state encodings recover to ESPERA_VEHICULO.

Test Plan:
- Normal entry: reset 2 cycles; llegada=1 -> ESPERA_CLAVE; clave=16'h1234 with strobe -> compuerta=1 on the next edge; ingreso=1, llegada=0 -> compuerta=0 next edge; alarms stay 0 throughout.
- Wrong PINs: llegada=1; three strobes of 16'h0000 -> alarma_pin=0 after strobes 1 and 2, =1 after strobe 3. A 4th wrong strobe -> intentos stays 3. llegada=0 -> state stays ESPERA_CLAVE. Strobe 16'h1234 -> alarma_pin=0, compuerta=1.
- Tailgating: gate open; ingreso=1 and llegada=1 same cycle -> compuerta=0, alarma_bloqueo=1. Strobe 16'h9999 -> no change. Strobe 16'h1234 -> alarma_bloqueo=0, ESPERA_VEHICULO.
- Timeout with TIMEOUT_CICLOS=8: open the gate and hold ingreso=0 -> compuerta high exactly 8 cycles, then 0; state ESPERA_VEHICULO.
- Reset mid-operation: assert reset while compuerta=1, and separately while alarma_bloqueo=1 -> all outputs 0 after one edge; a fresh correct-PIN sequence then opens the gate with intentos starting at 0.
- Edge cases:
  - Strobe a correct PIN in the same cycle llegada drops -> gate opens.
  - Strobe while in ESPERA_VEHICULO -> no output change.
